// File: rtl/spi_master_ctrl_if.sv
// Register-side bus of the SPI master: config, start/tx word, rx word and status.
// The host drives through the master modport; the controller sits on the slave modport.
interface spi_master_ctrl_if;
    logic        cfg_wr;
    logic [15:0] cfg_din;
    logic [15:0] cfg_q;
    logic        start;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic        busy;
    logic        done;

    modport master (
        output cfg_wr, cfg_din, start, tx_data,
        input  cfg_q, rx_data, busy, done
    );

    modport slave (
        input  cfg_wr, cfg_din, start, tx_data,
        output cfg_q, rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: one 1-32 bit word per start, programmable divider, CPOL/CPHA and bit order.
// Every phase (setup, each SCLK half-period, hold, gap) lasts DIV+1 clk cycles, paced by one shared tick.
module spi_master_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd3,
    parameter logic [4:0] DEFAULT_LEN = 5'd7
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.slave bus,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_csn
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cfg_q, cfg_d;
    logic [15:0] act_q, act_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  edge_q, edge_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [31:0] rx_q, rx_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic        done_q, done_d;

    logic        active, accept, tick, odd_edge, last_edge;
    logic        lsb_a, cpha_a, cpol_a;
    logic [4:0]  len_a;
    logic [6:0]  edge_num, two_n;
    logic [15:0] new_cfg;
    logic [31:0] aligned, rx_sampled;

    function automatic logic first_bit(input logic [31:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[31];
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] sr, input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    assign active   = (state_q != IDLE);
    assign accept   = bus.start && !active;
    assign new_cfg  = bus.cfg_wr ? bus.cfg_din : cfg_q;
    assign len_a    = act_q[12:8];
    assign cpol_a   = act_q[13];
    assign cpha_a   = act_q[14];
    assign lsb_a    = act_q[15];
    assign tick     = (cnt_q == act_q[7:0]);
    assign edge_num = edge_q + 7'd1;
    assign two_n    = {1'b0, len_a, 1'b0} + 7'd2;
    assign last_edge = (edge_num == two_n);
    assign odd_edge  = edge_num[0];

    // MSB-first words are pre-shifted so bit N-1 sits at bit 31 and always leaves from the top
    assign aligned    = new_cfg[15] ? bus.tx_data : (bus.tx_data << (5'd31 - new_cfg[12:8]));
    assign rx_sampled = lsb_a ? {spi_miso, rx_sr_q[31:1]} : {rx_sr_q[30:0], spi_miso};

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_sr_d = rx_sr_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        done_d  = 1'b0;

        if (bus.cfg_wr && !active) cfg_d = bus.cfg_din;

        case (state_q)
            IDLE: begin
                sclk_d = cfg_d[13];
                if (accept) begin
                    state_d = SETUP;
                    act_d   = new_cfg;
                    cnt_d   = 8'd0;
                    edge_d  = 7'd0;
                    rx_sr_d = 32'd0;
                    csn_d   = 1'b0;
                    if (new_cfg[14]) begin
                        tx_d   = aligned;
                        mosi_d = 1'b0;
                    end else begin
                        mosi_d = first_bit(aligned, new_cfg[15]);
                        tx_d   = shift_out(aligned, new_cfg[15]);
                    end
                end
            end
            SETUP, SHIFT: begin
                cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) begin
                    sclk_d  = ~sclk_q;
                    edge_d  = edge_num;
                    state_d = last_edge ? HOLD : SHIFT;
                    // Odd edges are leading edges: CPHA=0 samples there, CPHA=1 drives there
                    if (odd_edge) begin
                        if (cpha_a) begin
                            mosi_d = first_bit(tx_q, lsb_a);
                            tx_d   = shift_out(tx_q, lsb_a);
                        end else begin
                            rx_sr_d = rx_sampled;
                        end
                    end else begin
                        if (cpha_a) begin
                            rx_sr_d = rx_sampled;
                        end else if (!last_edge) begin
                            mosi_d = first_bit(tx_q, lsb_a);
                            tx_d   = shift_out(tx_q, lsb_a);
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) begin
                    state_d = GAP;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    sclk_d  = cpol_a;
                    rx_d    = lsb_a ? (rx_sr_q >> (5'd31 - len_a)) : rx_sr_q;
                end
            end
            GAP: begin
                cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= {3'b000, DEFAULT_LEN, DEFAULT_DIV};
            act_q   <= {3'b000, DEFAULT_LEN, DEFAULT_DIV};
            cnt_q   <= 8'd0;
            edge_q  <= 7'd0;
            rx_q    <= 32'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            done_q  <= done_d;
        end
    end

    // Shift registers are fully reloaded on every accepted start, so they carry no reset
    always_ff @(posedge clk) begin
        tx_q    <= tx_d;
        rx_sr_q <= rx_sr_d;
    end

    assign bus.cfg_q   = cfg_q;
    assign bus.rx_data = rx_q;
    assign bus.busy    = active;
    assign bus.done    = done_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_csn     = csn_q;
endmodule
